// File: rtl/header_remover_if.sv
// Avalon-ST style stream bundle used on both sides of header_remover.
// master drives data/valid/sop/eop and samples ready; slave is the mirror image.
interface header_remover_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  sop;
  logic                  eop;
  logic                  ready;

  modport master (output data, valid, sop, eop, input  ready);
  modport slave  (input  data, valid, sop, eop, output ready);
endinterface

// File: rtl/header_remover.sv
// Strips a fixed multi-word header from each packet and checks it against
// expected_header; matching packets have their payload forwarded and re-framed.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for sop, non-sop beats are discarded
// HEADER  | collecting/comparing header words after word 0
// PAYLOAD | header matched, forwarding payload through the output register
// DROP    | header mismatched, consuming beats until eop
module header_remover #(
  parameter int DATA_WIDTH   = 32,
  parameter int HEADER_WIDTH = 256,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [HEADER_WIDTH-1:0] expected_header,
  header_remover_if.slave         in_st,
  header_remover_if.master        out_st,
  output logic                    hdr_ok,
  output logic                    hdr_err,
  output logic                    short_err,
  output logic [CNT_WIDTH-1:0]    pkt_pass_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_drop_cnt
);

  localparam int HDR_WORDS = HEADER_WIDTH / DATA_WIDTH;
  localparam int IDX_W     = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       widx_q, widx_d;
  logic                   mis_q, mis_d;
  logic                   first_q, first_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic                   hdr_ok_q, hdr_ok_d;
  logic                   hdr_err_q, hdr_err_d;
  logic                   short_err_q, short_err_d;
  logic [CNT_WIDTH-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

  logic                   in_ready;
  logic                   accept;
  logic                   hdr_beat;
  logic [IDX_W-1:0]       cmp_idx;
  logic                   mis_prev;
  logic                   mis_now;
  logic [DATA_WIDTH-1:0]  exp_words [HDR_WORDS];

  // Word 0 of the header is the most significant slice.
  for (genvar k = 0; k < HDR_WORDS; k++) begin : g_exp
    assign exp_words[k] = expected_header[HEADER_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH];
  end

  assign in_ready    = (state_q == S_PAYLOAD) ? (!out_valid_q || out_st.ready) : 1'b1;
  assign accept      = in_st.valid && in_ready;
  assign in_st.ready = in_ready;

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    mis_d       = mis_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    hdr_ok_d    = 1'b0;
    hdr_err_d   = 1'b0;
    short_err_d = 1'b0;
    pass_cnt_d  = pass_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    hdr_beat    = 1'b0;
    cmp_idx     = '0;
    mis_prev    = 1'b0;
    mis_now     = 1'b0;

    if (out_valid_q && out_st.ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && in_st.sop) hdr_beat = 1'b1;
      end
      S_HEADER: begin
        if (accept) begin
          hdr_beat = 1'b1;
          if (in_st.sop) begin
            short_err_d = 1'b1;
            drop_cnt_d  = drop_cnt_d + CNT_WIDTH'(1);
          end else begin
            cmp_idx  = widx_q;
            mis_prev = mis_q;
          end
        end
      end
      S_PAYLOAD: begin
        if (in_st.valid && in_st.sop) begin
          // A stalled sop means the held word is the packet's last one.
          if (accept) hdr_beat = 1'b1;
          else        out_eop_d = 1'b1;
        end else if (accept) begin
          out_data_d  = in_st.data;
          out_valid_d = 1'b1;
          out_sop_d   = first_q;
          out_eop_d   = in_st.eop;
          first_d     = 1'b0;
          if (in_st.eop) state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (accept) begin
          if (in_st.sop)      hdr_beat = 1'b1;
          else if (in_st.eop) state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (hdr_beat) begin
      mis_now = mis_prev | (in_st.data != exp_words[cmp_idx]);
      if (cmp_idx == LAST_IDX) begin
        if (!mis_now) begin
          hdr_ok_d   = 1'b1;
          pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
          first_d    = 1'b1;
          state_d    = in_st.eop ? S_IDLE : S_PAYLOAD;
        end else begin
          hdr_err_d  = 1'b1;
          drop_cnt_d = drop_cnt_d + CNT_WIDTH'(1);
          state_d    = in_st.eop ? S_IDLE : S_DROP;
        end
      end else if (in_st.eop) begin
        short_err_d = 1'b1;
        drop_cnt_d  = drop_cnt_d + CNT_WIDTH'(1);
        state_d     = S_IDLE;
      end else begin
        state_d = S_HEADER;
        widx_d  = cmp_idx + IDX_W'(1);
        mis_d   = mis_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      widx_q      <= '0;
      mis_q       <= 1'b0;
      first_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      hdr_ok_q    <= 1'b0;
      hdr_err_q   <= 1'b0;
      short_err_q <= 1'b0;
      pass_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      mis_q       <= mis_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      hdr_ok_q    <= hdr_ok_d;
      hdr_err_q   <= hdr_err_d;
      short_err_q <= short_err_d;
      pass_cnt_q  <= pass_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_st.data  = out_data_q;
  assign out_st.valid = out_valid_q;
  assign out_st.sop   = out_sop_q;
  assign out_st.eop   = out_eop_q;
  assign hdr_ok       = hdr_ok_q;
  assign hdr_err      = hdr_err_q;
  assign short_err    = short_err_q;
  assign pkt_pass_cnt = pass_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_header_remover.sv
// Randomized self-checking bench for header_remover; expected output beats,
// counters and pulse totals come from a packet-level model.
module tb_header_remover;

  localparam int DW     = 32;
  localparam int HW     = 256;
  localparam int HWORDS = HW / DW;
  localparam int CW     = 16;

  localparam int K_GOOD  = 0;
  localparam int K_BAD   = 1;
  localparam int K_SHORT = 2;
  localparam int K_JUNK  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [HW-1:0] expected_header;
  logic          hdr_ok, hdr_err, short_err;
  logic [CW-1:0] pkt_pass_cnt, pkt_drop_cnt;

  always #5 clk = ~clk;

  header_remover_if #(.DATA_WIDTH(DW)) in_st ();
  header_remover_if #(.DATA_WIDTH(DW)) out_st ();

  header_remover #(.DATA_WIDTH(DW), .HEADER_WIDTH(HW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .expected_header (expected_header),
    .in_st           (in_st),
    .out_st          (out_st),
    .hdr_ok          (hdr_ok),
    .hdr_err         (hdr_err),
    .short_err       (short_err),
    .pkt_pass_cnt    (pkt_pass_cnt),
    .pkt_drop_cnt    (pkt_drop_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } beat_t;

  int            total = 0;
  int            bad = 0;
  beat_t         expq[$];
  beat_t         b;
  logic [CW-1:0] m_pass = '0;
  logic [CW-1:0] m_drop = '0;
  int            m_ok = 0, m_err = 0, m_short = 0;
  int            o_ok = 0, o_err = 0, o_short = 0;
  logic          in_tag = 1'b0;
  logic          acc_seen = 1'b0;
  logic          pend_lat = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_sop = 1'b0, prev_eop = 1'b0;
  int            rdy_mode = 0;
  bit            gap_en = 1'b0;
  bit            seq_pay = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr_word(input int w);
    logic [HW-1:0] h;
    h = expected_header;
    return h[HW-1-DW*w -: DW];
  endfunction

  // Monitor: everything is sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_seen   = 1'b0;
      pend_lat   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pend_lat) begin
        chk("lat_valid", 64'(out_st.valid), 64'(1));
        chk("lat_data", 64'(out_st.data), 64'(pend_data));
        pend_lat = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(out_st.valid), 64'(1));
        chk("stall_data", 64'(out_st.data), 64'(prev_data));
        chk("stall_sop", 64'(out_st.sop), 64'(prev_sop));
        chk("stall_eop", 64'(out_st.eop), 64'(prev_eop));
      end
      chk("rdy_rule", 64'(in_st.ready || (out_st.valid && !out_st.ready)), 64'(1));
      acc_seen = in_st.valid && in_st.ready;
      if (acc_seen && in_tag) begin
        pend_lat  = 1'b1;
        pend_data = in_st.data;
      end
      if (out_st.valid && out_st.ready) begin
        if (expq.size() == 0) begin
          chk("out_extra", 64'(out_st.data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          b = expq.pop_front();
          chk("out_data", 64'(out_st.data), 64'(b.d));
          chk("out_sop", 64'(out_st.sop), 64'(b.s));
          chk("out_eop", 64'(out_st.eop), 64'(b.e));
        end
      end
      prev_stall = out_st.valid && !out_st.ready;
      prev_data  = out_st.data;
      prev_sop   = out_st.sop;
      prev_eop   = out_st.eop;
      if (hdr_ok)    o_ok++;
      if (hdr_err)   o_err++;
      if (short_err) o_short++;
    end
  end

  initial begin
    out_st.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_st.ready = 1'b1;
        1:       out_st.ready = !out_st.ready;
        default: out_st.ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [DW-1:0] d, input bit s, input bit e, input bit tag);
    int n;
    n = 0;
    in_st.data  = d;
    in_st.sop   = s;
    in_st.eop   = e;
    in_st.valid = 1'b1;
    in_tag      = tag;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_seen && n < 200);
    #1;
    if (!acc_seen) chk("accept_timeout", 64'(0), 64'(1));
    in_st.valid = 1'b0;
    in_tag      = 1'b0;
    if (gap_en) idle(int'($urandom_range(0, 2)));
  endtask

  // kind: GOOD/BAD/SHORT/JUNK; arg = corrupted word, early-eop word or junk count.
  task automatic send_pkt(input int kind, input int npay, input int arg, input int cut);
    logic [DW-1:0] pay[$];
    logic [DW-1:0] d;
    bit            e;
    bit            stop;
    if (kind == K_JUNK) begin
      for (int j = 0; j < arg; j++) drive($urandom, 1'b0, ($urandom_range(0, 1) == 1), 1'b0);
      return;
    end
    for (int p = 0; p < npay; p++) pay.push_back(seq_pay ? DW'(p + 1) : $urandom);
    case (kind)
      K_GOOD: begin
        m_pass = m_pass + CW'(1);
        m_ok++;
        for (int p = 0; p < npay; p++) expq.push_back('{d: pay[p], s: (p == 0), e: (p == npay - 1)});
      end
      K_BAD: begin
        m_drop = m_drop + CW'(1);
        m_err++;
      end
      default: begin
        m_drop = m_drop + CW'(1);
        m_short++;
      end
    endcase
    stop = 1'b0;
    for (int w = 0; w < HWORDS && !stop; w++) begin
      d = hdr_word(w);
      if (kind == K_BAD && w == arg) d = '0;
      e = (kind == K_SHORT && w == arg) || (kind != K_SHORT && npay == 0 && w == HWORDS - 1);
      drive(d, (w == 0), e, 1'b0);
      stop = e;
    end
    if (!stop) begin
      for (int p = 0; p < npay; p++) begin
        if (cut >= 0 && p >= cut) break;
        drive(pay[p], 1'b0, (p == npay - 1), (kind == K_GOOD));
      end
    end
  endtask

  task automatic check_counts(input string tag);
    idle(2);
    chk({tag, "_pass_cnt"}, 64'(pkt_pass_cnt), 64'(m_pass));
    chk({tag, "_drop_cnt"}, 64'(pkt_drop_cnt), 64'(m_drop));
    chk({tag, "_ok_pulses"}, 64'(o_ok), 64'(m_ok));
    chk({tag, "_err_pulses"}, 64'(o_err), 64'(m_err));
    chk({tag, "_short_pulses"}, 64'(o_short), 64'(m_short));
  endtask

  task automatic drain(input string tag);
    rdy_mode = 0;
    for (int i = 0; i < 200 && expq.size() != 0; i++) idle(1);
    idle(2);
    chk({tag, "_drain"}, 64'(expq.size()), 64'(0));
  endtask

  initial begin
    int k;
    expected_header = {128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, {16{8'haa}}};
    in_st.data  = '0;
    in_st.valid = 1'b0;
    in_st.sop   = 1'b0;
    in_st.eop   = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 64'(in_st.ready), 64'(1));
    chk("rst_out_valid", 64'(out_st.valid), 64'(0));
    chk("rst_out_sop", 64'(out_st.sop), 64'(0));
    chk("rst_out_eop", 64'(out_st.eop), 64'(0));
    chk("rst_out_data", 64'(out_st.data), 64'(0));
    chk("rst_flags", 64'({hdr_ok, hdr_err, short_err}), 64'(0));
    chk("rst_pass_cnt", 64'(pkt_pass_cnt), 64'(0));
    chk("rst_drop_cnt", 64'(pkt_drop_cnt), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    seq_pay = 1'b1;
    send_pkt(K_GOOD, 3, 0, -1);
    check_counts("good");
    drain("good");

    send_pkt(K_BAD, 4, 3, -1);
    check_counts("mismatch");

    send_pkt(K_SHORT, 0, 4, -1);
    check_counts("short");
    send_pkt(K_GOOD, 3, 0, -1);
    check_counts("after_short");
    drain("after_short");

    rdy_mode = 1;
    send_pkt(K_GOOD, 10, 0, -1);
    check_counts("backpressure");
    drain("backpressure");

    send_pkt(K_GOOD, 0, 0, -1);
    send_pkt(K_GOOD, 3, 0, -1);
    check_counts("hdr_only");
    drain("hdr_only");

    send_pkt(K_GOOD, 5, 0, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_st.valid), 64'(0));
    chk("midrst_pass_cnt", 64'(pkt_pass_cnt), 64'(0));
    chk("midrst_drop_cnt", 64'(pkt_drop_cnt), 64'(0));
    expq.delete();
    m_pass = '0;
    m_drop = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(K_GOOD, 3, 0, -1);
    check_counts("after_rst");
    drain("after_rst");

    seq_pay  = 1'b0;
    gap_en   = 1'b1;
    for (int n = 0; n < 150; n++) begin
      rdy_mode = 2;
      k = int'($urandom_range(0, 9));
      if (k <= 3)      send_pkt(K_GOOD, int'($urandom_range(1, 6)), 0, -1);
      else if (k == 4) send_pkt(K_GOOD, 0, 0, -1);
      else if (k <= 6) send_pkt(K_BAD, int'($urandom_range(0, 4)), int'($urandom_range(0, HWORDS - 1)), -1);
      else if (k <= 8) send_pkt(K_SHORT, 0, int'($urandom_range(0, HWORDS - 2)), -1);
      else             send_pkt(K_JUNK, 0, int'($urandom_range(1, 3)), -1);
      check_counts("rand");
    end
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
